// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage side of the PC controller: request, abort,
// stall and delivery handshake with the instruction fetch FSM.
interface fetch_pc_ctrl_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic            abort_o;
   logic            stall_o;
   logic            stall_if_i;
   logic            instr_valid_i;
   logic            reset_able_i;

   modport master (
      output pc_o, pc_valid_o, abort_o, stall_o,
      input  stall_if_i, instr_valid_i, reset_able_i
   );

   modport slave (
      input  pc_o, pc_valid_o, abort_o, stall_o,
      output stall_if_i, instr_valid_i, reset_able_i
   );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC / fetch-request generator with redirect abort and an
// in-flight PC FIFO pairing each delivered instruction with its PC.
module fetch_pc_ctrl #(
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int              INFLIGHT_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             halt_i,
   input  logic             redirect_valid_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   input  logic             stall_pipe_i,
   fetch_pc_ctrl_if.master  fetch,
   output logic [XLEN-1:0]  pc_id_o,
   output logic             pc_id_valid_o,
   output logic             misaligned_o,
   output logic [1:0]       state_o
);
   localparam int AW = $clog2(INFLIGHT_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] mem_q [INFLIGHT_DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     cnt_q;

   logic active, flush, full, empty;
   logic issue, push, pop, bad_tgt;

   assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign flush   = redirect_valid_i && active;
   assign bad_tgt = |redirect_pc_i[1:0];
   assign full    = (cnt_q == (AW+1)'(INFLIGHT_DEPTH));
   assign empty   = (cnt_q == '0);

   assign issue = (state_q == S_RUN) && !full
                  && !redirect_valid_i && !halt_i;
   assign push  = issue && !fetch.stall_if_i && !stall_pipe_i;
   assign pop   = fetch.instr_valid_i && !empty && !flush;

   assign fetch.pc_o       = pc_q;
   assign fetch.pc_valid_o = issue;
   assign fetch.abort_o    = flush;
   assign fetch.stall_o    = stall_pipe_i;

   assign pc_id_o       = mem_q[rd_q];
   assign pc_id_valid_o = pop;
   assign misaligned_o  = mis_q;
   assign state_o       = state_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mis_d   = mis_q | (flush && bad_tgt);
      if (redirect_valid_i)
         pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (push)
         pc_d = pc_q + XLEN'(4);
      unique case (state_q)
         S_IDLE:
            if (start_i && !halt_i) state_d = S_RUN;
         S_RUN:
            if (flush && bad_tgt) state_d = S_HALT;
            else if (halt_i)      state_d = S_DRAIN;
         S_DRAIN:
            if (flush && bad_tgt) state_d = S_HALT;
            else if (fetch.reset_able_i && empty)
               state_d = S_HALT;
         S_HALT:
            if (start_i && !halt_i) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
      end
   end

   // Flush drops every in-flight PC; a redirect never pushes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < INFLIGHT_DEPTH; i++)
            mem_q[i] <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= pc_q;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop)
            rd_q <= rd_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequencing, stalls, FIFO
// back-pressure, redirect/abort, misalignment, halt/drain, wrap.
module tb_fetch_pc_ctrl;
   logic        clk = 0;
   logic        reset = 0;
   logic        start_i = 0;
   logic        halt_i = 0;
   logic        redirect_valid_i = 0;
   logic [31:0] redirect_pc_i = '0;
   logic        stall_pipe_i = 0;
   logic [31:0] pc_id_o;
   logic        pc_id_valid_o;
   logic        misaligned_o;
   logic [1:0]  state_o;
   int          passed = 0;
   int          total = 0;

   fetch_pc_ctrl_if #(.XLEN(32)) fif ();

   fetch_pc_ctrl #(
      .XLEN(32), .RESET_PC(32'h0), .INFLIGHT_DEPTH(2)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .halt_i(halt_i), .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i(redirect_pc_i), .stall_pipe_i(stall_pipe_i),
      .fetch(fif.master), .pc_id_o(pc_id_o),
      .pc_id_valid_o(pc_id_valid_o), .misaligned_o(misaligned_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
      #1;
   endtask

   task automatic start_run();
      do_reset();
      start_i = 1;
      tick();
      start_i = 0;
      #1;
   endtask

   task automatic test_reset();
      fif.stall_if_i = 0; fif.instr_valid_i = 0; fif.reset_able_i = 0;
      do_reset();
      total++; if (fif.pc_o !== 32'h0) $display("FAIL rst_pc got=%h exp=0", fif.pc_o); else passed++;
      total++; if (fif.pc_valid_o !== 1'b0) $display("FAIL rst_pc_valid got=%b exp=0", fif.pc_valid_o); else passed++;
      total++; if (fif.abort_o !== 1'b0) $display("FAIL rst_abort got=%b exp=0", fif.abort_o); else passed++;
      total++; if (pc_id_valid_o !== 1'b0) $display("FAIL rst_id_valid got=%b exp=0", pc_id_valid_o); else passed++;
      total++; if (pc_id_o !== 32'h0) $display("FAIL rst_pc_id got=%h exp=0", pc_id_o); else passed++;
      total++; if (misaligned_o !== 1'b0) $display("FAIL rst_mis got=%b exp=0", misaligned_o); else passed++;
      total++; if (state_o !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state_o); else passed++;
   endtask

   task automatic test_sequential();
      start_run();
      total++; if (state_o !== 2'd1) $display("FAIL seq_state got=%0d exp=1", state_o); else passed++;
      for (int i = 0; i < 4; i++) begin
         fif.instr_valid_i = (i > 0);
         #1;
         total++; if (fif.pc_o !== 32'(4*i)) $display("FAIL seq_pc%0d got=%h exp=%h", i, fif.pc_o, 32'(4*i)); else passed++;
         total++; if (fif.pc_valid_o !== 1'b1) $display("FAIL seq_valid%0d got=%b exp=1", i, fif.pc_valid_o); else passed++;
         if (i > 0) begin
            total++; if (pc_id_valid_o !== 1'b1) $display("FAIL seq_idv%0d got=%b exp=1", i, pc_id_valid_o); else passed++;
            total++; if (pc_id_o !== 32'(4*(i-1))) $display("FAIL seq_id%0d got=%h exp=%h", i, pc_id_o, 32'(4*(i-1))); else passed++;
         end
         tick();
      end
      fif.instr_valid_i = 0;
   endtask

   task automatic test_stall();
      start_run();
      tick();
      fif.instr_valid_i = 1;
      tick();
      fif.stall_if_i = 1;
      #1;
      total++; if (fif.pc_o !== 32'h8) $display("FAIL stall_pc0 got=%h exp=8", fif.pc_o); else passed++;
      total++; if (pc_id_o !== 32'h4) $display("FAIL stall_id got=%h exp=4", pc_id_o); else passed++;
      tick();
      fif.instr_valid_i = 0;
      for (int i = 1; i < 3; i++) begin
         #1;
         total++; if (fif.pc_o !== 32'h8) $display("FAIL stall_pc%0d got=%h exp=8", i, fif.pc_o); else passed++;
         tick();
      end
      fif.stall_if_i = 0;
      stall_pipe_i = 1;
      #1;
      total++; if (fif.stall_o !== 1'b1) $display("FAIL stall_o_hi got=%b exp=1", fif.stall_o); else passed++;
      tick();
      stall_pipe_i = 0;
      fif.instr_valid_i = 1;
      #1;
      total++; if (fif.stall_o !== 1'b0) $display("FAIL stall_o_lo got=%b exp=0", fif.stall_o); else passed++;
      total++; if (fif.pc_o !== 32'h8) $display("FAIL stall_pipe_hold got=%h exp=8", fif.pc_o); else passed++;
      total++; if (pc_id_valid_o !== 1'b0) $display("FAIL stall_nopush got=%b exp=0", pc_id_valid_o); else passed++;
      tick();
      #1;
      total++; if (fif.pc_o !== 32'hC) $display("FAIL stall_adv got=%h exp=c", fif.pc_o); else passed++;
      total++; if (pc_id_o !== 32'h8 || pc_id_valid_o !== 1'b1) $display("FAIL stall_deliver got=%h/%b exp=8/1", pc_id_o, pc_id_valid_o); else passed++;
      fif.instr_valid_i = 0;
   endtask

   task automatic test_fifo_full();
      start_run();
      tick();
      tick();
      total++; if (fif.pc_o !== 32'h8 || fif.pc_valid_o !== 1'b0) $display("FAIL full_block got=%h/%b exp=8/0", fif.pc_o, fif.pc_valid_o); else passed++;
      tick();
      fif.instr_valid_i = 1;
      #1;
      total++; if (pc_id_valid_o !== 1'b1 || pc_id_o !== 32'h0) $display("FAIL full_pop got=%b/%h exp=1/0", pc_id_valid_o, pc_id_o); else passed++;
      total++; if (fif.pc_valid_o !== 1'b0) $display("FAIL full_still got=%b exp=0", fif.pc_valid_o); else passed++;
      tick();
      fif.instr_valid_i = 0;
      #1;
      total++; if (fif.pc_valid_o !== 1'b1 || fif.pc_o !== 32'h8) $display("FAIL full_resume got=%b/%h exp=1/8", fif.pc_valid_o, fif.pc_o); else passed++;
      total++; if (pc_id_o !== 32'h4) $display("FAIL full_head got=%h exp=4", pc_id_o); else passed++;
   endtask

   task automatic test_redirect();
      start_run();
      tick();
      tick();
      redirect_valid_i = 1;
      redirect_pc_i = 32'h100;
      fif.instr_valid_i = 1;
      #1;
      total++; if (fif.abort_o !== 1'b1) $display("FAIL redir_abort got=%b exp=1", fif.abort_o); else passed++;
      total++; if (fif.pc_valid_o !== 1'b0) $display("FAIL redir_valid got=%b exp=0", fif.pc_valid_o); else passed++;
      total++; if (pc_id_valid_o !== 1'b0) $display("FAIL redir_flushwin got=%b exp=0", pc_id_valid_o); else passed++;
      tick();
      redirect_valid_i = 0;
      #1;
      total++; if (fif.abort_o !== 1'b0) $display("FAIL redir_pulse got=%b exp=0", fif.abort_o); else passed++;
      total++; if (fif.pc_o !== 32'h100 || fif.pc_valid_o !== 1'b1) $display("FAIL redir_pc got=%h/%b exp=100/1", fif.pc_o, fif.pc_valid_o); else passed++;
      total++; if (pc_id_valid_o !== 1'b0) $display("FAIL redir_flushed got=%b exp=0", pc_id_valid_o); else passed++;
      tick();
      #1;
      total++; if (pc_id_valid_o !== 1'b1 || pc_id_o !== 32'h100) $display("FAIL redir_deliver got=%b/%h exp=1/100", pc_id_valid_o, pc_id_o); else passed++;
      total++; if (fif.pc_o !== 32'h104) $display("FAIL redir_next got=%h exp=104", fif.pc_o); else passed++;
      fif.instr_valid_i = 0;
   endtask

   task automatic test_misaligned();
      start_run();
      redirect_valid_i = 1;
      redirect_pc_i = 32'h102;
      #1;
      total++; if (fif.abort_o !== 1'b1) $display("FAIL mis_abort got=%b exp=1", fif.abort_o); else passed++;
      tick();
      redirect_valid_i = 0;
      #1;
      total++; if (misaligned_o !== 1'b1) $display("FAIL mis_flag got=%b exp=1", misaligned_o); else passed++;
      total++; if (state_o !== 2'd3) $display("FAIL mis_state got=%0d exp=3", state_o); else passed++;
      total++; if (fif.pc_o !== 32'h100 || fif.pc_valid_o !== 1'b0) $display("FAIL mis_pc got=%h/%b exp=100/0", fif.pc_o, fif.pc_valid_o); else passed++;
      start_i = 1;
      tick();
      start_i = 0;
      #1;
      total++; if (state_o !== 2'd1 || misaligned_o !== 1'b1) $display("FAIL mis_restart got=%0d/%b exp=1/1", state_o, misaligned_o); else passed++;
      do_reset();
      total++; if (misaligned_o !== 1'b0 || fif.pc_o !== 32'h0) $display("FAIL mis_clear got=%b/%h exp=0/0", misaligned_o, fif.pc_o); else passed++;
   endtask

   task automatic test_halt();
      start_run();
      tick();
      halt_i = 1;
      #1;
      total++; if (fif.pc_valid_o !== 1'b0) $display("FAIL halt_novalid got=%b exp=0", fif.pc_valid_o); else passed++;
      tick();
      fif.instr_valid_i = 1;
      #1;
      total++; if (state_o !== 2'd2) $display("FAIL halt_drain got=%0d exp=2", state_o); else passed++;
      total++; if (pc_id_valid_o !== 1'b1 || pc_id_o !== 32'h0) $display("FAIL halt_deliver got=%b/%h exp=1/0", pc_id_valid_o, pc_id_o); else passed++;
      tick();
      fif.instr_valid_i = 0;
      #1;
      total++; if (state_o !== 2'd2) $display("FAIL halt_wait got=%0d exp=2", state_o); else passed++;
      tick();
      fif.reset_able_i = 1;
      tick();
      fif.reset_able_i = 0;
      #1;
      total++; if (state_o !== 2'd3) $display("FAIL halt_parked got=%0d exp=3", state_o); else passed++;
      start_i = 1;
      tick();
      #1;
      total++; if (state_o !== 2'd3) $display("FAIL halt_startign got=%0d exp=3", state_o); else passed++;
      halt_i = 0;
      tick();
      start_i = 0;
      #1;
      total++; if (state_o !== 2'd1 || fif.pc_o !== 32'h4 || fif.pc_valid_o !== 1'b1) $display("FAIL halt_resume got=%0d/%h/%b exp=1/4/1", state_o, fif.pc_o, fif.pc_valid_o); else passed++;
   endtask

   task automatic test_wrap_idle();
      start_run();
      redirect_valid_i = 1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      redirect_valid_i = 0;
      #1;
      total++; if (fif.pc_o !== 32'hFFFF_FFFC || fif.pc_valid_o !== 1'b1) $display("FAIL wrap_top got=%h/%b exp=fffffffc/1", fif.pc_o, fif.pc_valid_o); else passed++;
      tick();
      total++; if (fif.pc_o !== 32'h0) $display("FAIL wrap_zero got=%h exp=0", fif.pc_o); else passed++;
      do_reset();
      redirect_valid_i = 1;
      redirect_pc_i = 32'h40;
      #1;
      total++; if (fif.abort_o !== 1'b0) $display("FAIL idle_noabort got=%b exp=0", fif.abort_o); else passed++;
      tick();
      redirect_valid_i = 0;
      #1;
      total++; if (fif.pc_o !== 32'h40 || state_o !== 2'd0) $display("FAIL idle_load got=%h/%0d exp=40/0", fif.pc_o, state_o); else passed++;
   endtask

   initial begin
      fif.stall_if_i = 0;
      fif.instr_valid_i = 0;
      fif.reset_able_i = 0;
      #2;
      test_reset();
      test_sequential();
      test_stall();
      test_fifo_full();
      test_redirect();
      test_misaligned();
      test_halt();
      test_wrap_idle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Program-counter and fetch-request generator directly upstream of the instruction-memory fetch FSM.
- Drives the PC and request-valid into the fetch stage and reacts to its IF stall.
- Generates abort pulses on branch/jump redirects.
- Tracks in-flight fetch PCs in a small FIFO so decode receives the PC that matches each delivered instruction.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC loaded on reset
INFLIGHT_DEPTH, 2, in-flight PC FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start_i  in  1  leave IDLE/HALT and begin fetching
halt_i  in  1  request to stop fetching (level)
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_pc_i  in  XLEN  redirect target
stall_if_i  in  1  fetch stage not ready for a new PC (fetch STALL_IF)
stall_pipe_i  in  1  downstream pipeline stall
instr_valid_i  in  1  fetch stage delivers an instruction to decode this cycle
reset_able_i  in  1  fetch stage idle with no request pending
pc_o  out  XLEN  PC presented to fetch
pc_valid_o  out  1  fetch request valid
abort_o  out  1  abort current/in-flight fetch (to fetch abort_rvalid)
stall_o  out  1  stall to fetch stage (fetch stall_in)
pc_id_o  out  XLEN  PC of instruction delivered to decode
pc_id_valid_o  out  1  pc_id_o valid
misaligned_o  out  1  sticky: redirect target not word aligned
state_o  out  2  current FSM state

Behaviour:
- Reset (clk edge with reset=1) values:
  - pc_o=RESET_PC; pc_valid_o=0, abort_o=0, pc_id_valid_o=0, misaligned_o=0; pc_id_o=0.
  - FIFO empty; state=S_IDLE.
  - Reset mid-operation discards all in-flight PCs.
- States (state_o encoding):
  - S_IDLE=0: no requests; start_i -> S_RUN.
  - S_RUN=1: issuing fetches.
  - S_DRAIN=2: halt requested; no new requests; -> S_HALT when reset_able_i=1 and FIFO empty.
  - S_HALT=3: parked; start_i (and halt_i=0) -> S_RUN; misaligned_o does not block restart.
- Issue:
  - pc_valid_o = (state==S_RUN) && !fifo_full && !redirect_valid_i && !halt_i.
  - Accept = pc_valid_o && !stall_if_i && !stall_pipe_i.
  - On accept: pc_o <= pc_o+4 (mod 2^XLEN, wraps 0xFFFF_FFFC -> 0) and pc_o is pushed to the FIFO.
  - Without accept, pc_o holds (stable under stall).
- stall_o = stall_pipe_i (pure pass-through, zero latency).
- Delivery:
  - pc_id_o = FIFO head (combinational).
  - pc_id_valid_o = instr_valid_i && !fifo_empty; FIFO pops on that condition.
  - instr_valid_i with FIFO empty is ignored.
  - Push and pop in the same cycle: both take effect, occupancy unchanged.
- Redirect (redirect_valid_i=1 in S_RUN or S_DRAIN):
  - abort_o=1 combinationally the same cycle (one-cycle pulse per redirect cycle).
  - pc_valid_o=0 that cycle; FIFO flushed; pc_o <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - First request at the new PC is presented the next cycle.
  - If redirect_pc_i[1:0]!=0: misaligned_o <= 1 (sticky until reset), next state S_HALT.
  - Redirect in S_IDLE/S_HALT: pc_o loads the target, no abort, state unchanged.
- Halt:
  - halt_i in S_RUN -> S_DRAIN next cycle; pc_valid_o already 0 in the halt_i cycle.
  - In-flight PCs are still delivered during drain.
- Simultaneous events:
  - redirect + halt: redirect PC loaded and FIFO flushed, then S_DRAIN.
  - redirect + instr_valid_i: flush wins, pc_id_valid_o=0.
  - start_i with halt_i=1: start is ignored.

Test Plan:
- Reset then start_i, stall_if_i=0, instr_valid_i one cycle after each accept -> pc_o 0x0,0x4,0x8,0xC on consecutive cycles; pc_id_o follows one cycle behind; state_o=1.
- stall_if_i=1 for 3 cycles at pc_o=0x8 -> pc_o holds 0x8, no push; advances to 0xC the cycle after stall_if_i falls.
- FIFO fill: 2 accepts with no instr_valid_i -> pc_valid_o=0 at pc_o=0x8. One instr_valid_i -> pc_id_o=0x0, then pc_valid_o=1.
- Redirect to 0x100 with 2 PCs in flight -> abort_o=1 for one cycle, pc_valid_o=0; next cycle pc_o=0x100. A following instr_valid_i yields no pc_id_valid_o (FIFO flushed).
- Redirect to 0x102 -> misaligned_o=1, state_o=3, pc_o=0x100. Reset clears misaligned_o and sets pc_o=RESET_PC.
- halt_i with 1 PC in flight, reset_able_i=0 -> state_o=2; instr_valid_i delivers the PC. reset_able_i=1 -> state_o=3. start_i -> resumes at the next sequential PC.
